// File: rtl/instr_decoder_pkg.sv
// Shared decoder/encoder definitions: ALU ops, encoder request kinds, RV32 opcodes and the
// per-op funct3/funct7 lookup used when packing instruction words.
package instr_decoder_pkg;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8
  } alu_op_e;

  typedef enum logic [2:0] {
    KIND_R     = 3'd0,
    KIND_I     = 3'd1,
    KIND_B     = 3'd2,
    KIND_LOAD  = 3'd3,
    KIND_STORE = 3'd4
  } enc_kind_e;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic       ok;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } alu_fields_t;

  // ok=0 marks ops with no R/I encoding (ALU_NOP and out-of-range values)
  function automatic alu_fields_t alu_fields(input alu_op_e op);
    alu_fields_t f;
    f.ok     = 1'b1;
    f.funct3 = 3'b000;
    f.funct7 = 7'b0000000;
    case (op)
      ALU_ADD: f.funct3 = 3'b000;
      ALU_SUB: begin
        f.funct3 = 3'b000;
        f.funct7 = 7'b0100000;
      end
      ALU_AND: f.funct3 = 3'b111;
      ALU_OR:  f.funct3 = 3'b110;
      ALU_XOR: f.funct3 = 3'b100;
      ALU_SLT: f.funct3 = 3'b010;
      ALU_SLL: f.funct3 = 3'b001;
      ALU_SRL: f.funct3 = 3'b101;
      default: f.ok = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Circular FIFO holding encoded words. The caller gates push/pop against full/empty;
// pointers are log2(DEPTH) wide so they wrap modulo DEPTH on their own.
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               data_i,
  output logic [WIDTH-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO's head is masked by the caller
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end

  assign data_o = mem[rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Packs R/I-ALU, BEQ, LW and SW requests into RV32 words and queues them in a DEPTH-entry FIFO.
// Define INSTR_ENC_ERR_EN to drop illegal requests and pulse err_o; otherwise they enqueue a NOP.
module instr_encoder
  import instr_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  enc_kind_e                    req_kind_i,
  input  alu_op_e                      alu_op_i,
  input  logic [4:0]                   rd_i,
  input  logic [4:0]                   rs1_i,
  input  logic [4:0]                   rs2_i,
  input  logic [12:0]                  imm_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [31:0]                  instr_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         err_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  alu_fields_t fields;
  logic [31:0] enc_word;
  logic        illegal;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] push_data;
  logic [31:0] fifo_head;

  // Illegal requests leave enc_word at NOP so either build can use it directly
  always_comb begin
    fields   = alu_fields(alu_op_i);
    enc_word = INSTR_NOP;
    illegal  = 1'b0;
    case (req_kind_i)
      KIND_R: begin
        if (!fields.ok) illegal = 1'b1;
        else enc_word = {fields.funct7, rs2_i, rs1_i, fields.funct3, rd_i, OPC_R};
      end
      KIND_I: begin
        if (!fields.ok || alu_op_i == ALU_SUB) illegal = 1'b1;
        else if (alu_op_i == ALU_SLL || alu_op_i == ALU_SRL)
          enc_word = {7'b0000000, imm_i[4:0], rs1_i, fields.funct3, rd_i, OPC_I};
        else
          enc_word = {imm_i[11:0], rs1_i, fields.funct3, rd_i, OPC_I};
      end
      KIND_B: begin
        if (imm_i[0]) illegal = 1'b1;
        else enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, F3_BEQ,
                         imm_i[4:1], imm_i[11], OPC_B};
      end
      KIND_LOAD:  enc_word = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OPC_LOAD};
      KIND_STORE: enc_word = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
      default:    illegal = 1'b1;
    endcase
  end

  assign req_ready_o   = (count_o != FULL_CNT);
  assign instr_valid_o = (count_o != '0);
  assign accept        = req_valid_i && req_ready_o;
  assign pop           = instr_valid_o && instr_ready_i;

`ifdef INSTR_ENC_ERR_EN
  logic err_q;

  assign push      = accept && !illegal;
  assign push_data = enc_word;
  assign err_o     = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= accept && illegal;
  end
`else
  assign push      = accept;
  assign push_data = illegal ? INSTR_NOP : enc_word;
  assign err_o     = 1'b0;
`endif

  instr_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (fifo_head),
    .count_o (count_o)
  );

  assign instr_o = instr_valid_o ? fifo_head : INSTR_NOP;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, FIFO fill/drain and reset
// sequences, then random traffic against a queue-based reference model.
module tb_instr_encoder;
  import instr_decoder_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_ENC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  enc_kind_e   req_kind_i;
  alu_op_e     alu_op_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [12:0] imm_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_kind_i    (req_kind_i),
    .alu_op_i      (alu_op_i),
    .rd_i          (rd_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .imm_i         (imm_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .count_o       (count_o),
    .err_o         (err_o)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] model_q[$];
  bit err_exp = 1'b0;

  typedef struct {
    int kind; int op; int rd; int rs1; int rs2; int imm;
    bit bad; logic [31:0] word;
  } vec_t;
  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference encoder built straight from the field layout with shifts and masks
  function automatic logic [31:0] model_encode(input int kind, input int op, input int rd,
      input int rs1, input int rs2, input int imm, output bit bad);
    logic [31:0] w, f3, f7, i12, i13, r_d, r_1, r_2;
    bit alu_ok;
    alu_ok = 1'b1; f3 = 0; f7 = 0; bad = 1'b0; w = NOP;
    i13 = 32'(imm) & 32'h1FFF; i12 = i13 & 32'hFFF;
    r_d = 32'(rd); r_1 = 32'(rs1); r_2 = 32'(rs2);
    if      (op == int'(ALU_ADD)) f3 = 0;
    else if (op == int'(ALU_SUB)) begin f3 = 0; f7 = 32; end
    else if (op == int'(ALU_AND)) f3 = 7;
    else if (op == int'(ALU_OR))  f3 = 6;
    else if (op == int'(ALU_XOR)) f3 = 4;
    else if (op == int'(ALU_SLT)) f3 = 2;
    else if (op == int'(ALU_SLL)) f3 = 1;
    else if (op == int'(ALU_SRL)) f3 = 5;
    else alu_ok = 1'b0;
    case (kind)
      0: begin
        bad = !alu_ok;
        w = 32'h33 + (r_d << 7) + (f3 << 12) + (r_1 << 15) + (r_2 << 20) + (f7 << 25);
      end
      1: begin
        bad = !alu_ok || op == int'(ALU_SUB);
        if (op == int'(ALU_SLL) || op == int'(ALU_SRL)) i12 = i13 & 32'd31;
        w = 32'h13 + (r_d << 7) + (f3 << 12) + (r_1 << 15) + (i12 << 20);
      end
      2: begin
        bad = i13[0];
        w = 32'h63 + (((i13 >> 11) & 1) << 7) + (((i13 >> 1) & 15) << 8) + (r_1 << 15)
            + (r_2 << 20) + (((i13 >> 5) & 63) << 25) + (((i13 >> 12) & 1) << 31);
      end
      3: w = 32'h03 + (r_d << 7) + (32'd2 << 12) + (r_1 << 15) + (i12 << 20);
      4: w = 32'h23 + ((i12 & 31) << 7) + (32'd2 << 12) + (r_1 << 15) + (r_2 << 20)
             + ((i12 >> 5) << 25);
      default: bad = 1'b1;
    endcase
    if (bad) w = NOP;
    return w;
  endfunction

  task automatic checkModel(input string tag);
    checkOutput({tag, ".count"}, 32'(count_o), 32'(model_q.size()));
    checkOutput({tag, ".instr_valid"}, 32'(instr_valid_o), 32'(model_q.size() != 0));
    checkOutput({tag, ".req_ready"}, 32'(req_ready_o), 32'(model_q.size() != DEPTH));
    checkOutput({tag, ".instr"}, instr_o, (model_q.size() != 0) ? model_q[0] : NOP);
    checkOutput({tag, ".err"}, 32'(err_o), 32'(err_exp));
  endtask

  // Called at a falling edge: check state, drive one cycle of inputs, advance the model
  task automatic applyStimulus(input bit v, input int kind, input int op, input int rd,
      input int rs1, input int rs2, input int imm, input bit rdy);
    logic [31:0] word;
    bit bad, acc, pp;
    checkModel("model");
    req_valid_i   = v;
    req_kind_i    = enc_kind_e'(kind[2:0]);
    alu_op_i      = alu_op_e'(op[3:0]);
    rd_i          = rd[4:0];
    rs1_i         = rs1[4:0];
    rs2_i         = rs2[4:0];
    imm_i         = imm[12:0];
    instr_ready_i = rdy;
    @(posedge clk_i);
    word = model_encode(kind, op, rd, rs1, rs2, imm, bad);
    acc  = v && (model_q.size() != DEPTH);
    pp   = rdy && (model_q.size() != 0);
    if (pp) void'(model_q.pop_front());
    if (acc && !(ERR_EN && bad)) model_q.push_back(word);
    err_exp = ERR_EN && acc && bad;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic pushVec(input int i, input bit rdy);
    applyStimulus(1'b1, vecs[i].kind, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, rdy);
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    vecs.push_back('{0, int'(ALU_SUB), 3, 1, 2, 0,       1'b0, 32'h402081B3});
    vecs.push_back('{1, int'(ALU_ADD), 5, 0, 0, 'hFFF,   1'b0, 32'hFFF00293});
    vecs.push_back('{3, int'(ALU_NOP), 4, 2, 0, 16,      1'b0, 32'h01012203});
    vecs.push_back('{2, int'(ALU_ADD), 9, 1, 2, 8,       1'b0, 32'h00208463});
    vecs.push_back('{0, int'(ALU_AND), 1, 2, 3, 0,       1'b0, 32'h003170B3});
    vecs.push_back('{1, int'(ALU_SRL), 7, 6, 0, 'hFE3,   1'b0, 32'h00335393});
    vecs.push_back('{4, int'(ALU_NOP), 0, 2, 5, 8,       1'b0, 32'h00512423});
    vecs.push_back('{2, int'(ALU_NOP), 0, 0, 0, 'h1FFC,  1'b0, 32'hFE000EE3});
    vecs.push_back('{2, int'(ALU_NOP), 0, 1, 2, 9,       1'b1, NOP});
    vecs.push_back('{0, int'(ALU_NOP), 3, 1, 2, 0,       1'b1, NOP});
    vecs.push_back('{1, int'(ALU_SUB), 3, 1, 0, 5,       1'b1, NOP});
    vecs.push_back('{5, int'(ALU_ADD), 3, 1, 2, 0,       1'b1, NOP});
    vecs.push_back('{7, int'(ALU_ADD), 3, 1, 2, 0,       1'b1, NOP});

    rst_i = 1'b1; req_valid_i = 1'b0; instr_ready_i = 1'b0;
    req_kind_i = KIND_R; alu_op_i = ALU_NOP; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    @(negedge clk_i);
    checkOutput("reset.count", 32'(count_o), 0);
    checkOutput("reset.instr_valid", 32'(instr_valid_o), 0);
    checkOutput("reset.req_ready", 32'(req_ready_o), 1);
    checkOutput("reset.err", 32'(err_o), 0);
    checkOutput("reset.instr", instr_o, 32'h0000_0013);
    rst_i = 1'b0;

    // Each vector alone: word at head one cycle after accept, then drained
    for (int i = 0; i < vecs.size(); i++) begin
      pushVec(i, 1'b1);
`ifdef INSTR_ENC_ERR_EN
      if (vecs[i].bad) begin
        checkOutput($sformatf("vec%0d.err", i), 32'(err_o), 1);
        checkOutput($sformatf("vec%0d.count", i), 32'(count_o), 0);
      end else begin
        checkOutput($sformatf("vec%0d.word", i), instr_o, vecs[i].word);
      end
`else
      checkOutput($sformatf("vec%0d.word", i), instr_o, vecs[i].word);
      checkOutput($sformatf("vec%0d.count", i), 32'(count_o), 1);
`endif
      idle(1'b1);
    end

    // Fill with consumer stalled, then drain in order with one overlapped push+pop
    for (int i = 0; i < 4; i++) pushVec(i, 1'b0);
    checkOutput("full.count", 32'(count_o), 4);
    checkOutput("full.req_ready", 32'(req_ready_o), 0);
    checkOutput("full.head", instr_o, vecs[0].word);
    pushVec(4, 1'b0);
    checkOutput("full.hold_count", 32'(count_o), 4);
    pushVec(5, 1'b1);
    checkOutput("drain1.head", instr_o, vecs[1].word);
    checkOutput("drain1.count", 32'(count_o), 3);
    pushVec(6, 1'b1);
    checkOutput("overlap.count", 32'(count_o), 3);
    checkOutput("overlap.head", instr_o, vecs[2].word);
    idle(1'b1);
    checkOutput("drain3.head", instr_o, vecs[3].word);
    idle(1'b1);
    checkOutput("drain4.head", instr_o, vecs[6].word);
    idle(1'b1);
    checkOutput("drained.instr", instr_o, NOP);
    checkOutput("drained.valid", 32'(instr_valid_o), 0);

    // Reset asserted mid-cycle with two entries queued
    pushVec(0, 1'b0);
    pushVec(1, 1'b0);
    checkOutput("prereset.count", 32'(count_o), 2);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("midreset.instr_valid", 32'(instr_valid_o), 0);
    checkOutput("midreset.count", 32'(count_o), 0);
    checkOutput("midreset.instr", instr_o, NOP);
    model_q.delete();
    err_exp = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    pushVec(7, 1'b0);
    checkOutput("postreset.head", instr_o, vecs[7].word);
    checkOutput("postreset.count", 32'(count_o), 1);
    idle(1'b1);

    // Random traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      int k;
      k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      applyStimulus($urandom_range(0, 3) != 0, k, int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 8191)),
                    $urandom_range(0, 2) != 0);
    end
    for (int n = 0; n < DEPTH + 1; n++) idle(1'b1);
    checkModel("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
